// File: rtl/aibcr3_dcc_dly_cal.sv
// DCC delay-line calibration controller: 11-bit successive-approximation search
// with majority-voted phase-detector samples, ending in a locked gray code.
module aibcr3_dcc_dly_cal #(
    parameter int PULSE_W    = 1,
    parameter int SETTLE_CYC = 4,
    parameter int N_SAMPLE   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cal_en,
    input  logic        pd_early,
    output logic        launch,
    output logic        measure,
    output logic [10:0] gray,
    output logic        dll_lock_reg,
    output logic        cal_busy,
    output logic [10:0] code_bin
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PULSE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DECIDE = 3'd4,
        LOCKED = 3'd5
    } state_t;

    localparam logic [7:0]  PULSE_LAST  = 8'(PULSE_W - 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [2:0]  SMP_LAST    = 3'(N_SAMPLE - 1);
    localparam logic [2:0]  VOTE_HALF   = 3'(N_SAMPLE / 2);
    localparam logic [10:0] FIRST_TRIAL = 11'h400;

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [2:0]  smp_r;
    logic [2:0]  vote_r;
    logic [3:0]  bit_idx_r;
    logic [10:0] code_bin_r;
    logic [10:0] gray_r;
    logic        launch_r;
    logic        measure_r;
    logic        lock_r;
    logic        busy_r;
    logic        pd_meta_r;
    logic        pd_s_r;
    logic [10:0] trial_mask_s;
    logic        keep_s;
    logic [10:0] decide_code_s;

    function automatic logic [10:0] bin2gray(input logic [10:0] b);
        return b ^ (b >> 1);
    endfunction

    // Two-flop synchronizer for the asynchronous phase-detector output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pd_meta_r <= 1'b0;
            pd_s_r    <= 1'b0;
        end else begin
            pd_meta_r <= pd_early;
            pd_s_r    <= pd_meta_r;
        end
    end

    // Resolve the current trial bit and load the next one below it
    always_comb begin
        trial_mask_s  = 11'd1 << bit_idx_r;
        keep_s        = (vote_r > VOTE_HALF);
        decide_code_s = code_bin_r;
        if (keep_s) begin
            decide_code_s = code_bin_r;
        end else begin
            decide_code_s = code_bin_r & ~trial_mask_s;
        end
        if (bit_idx_r != 4'd0) begin
            decide_code_s = decide_code_s | (trial_mask_s >> 1);
        end else begin
            decide_code_s = decide_code_s;
        end
    end

    // Search sequencer with registered outputs; dropping cal_en clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= 8'd0;
            smp_r      <= 3'd0;
            vote_r     <= 3'd0;
            bit_idx_r  <= 4'd0;
            code_bin_r <= 11'd0;
            gray_r     <= 11'd0;
            launch_r   <= 1'b0;
            measure_r  <= 1'b0;
            lock_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else if (!cal_en) begin
            state_r    <= IDLE;
            cnt_r      <= 8'd0;
            smp_r      <= 3'd0;
            vote_r     <= 3'd0;
            bit_idx_r  <= 4'd0;
            code_bin_r <= 11'd0;
            gray_r     <= 11'd0;
            launch_r   <= 1'b0;
            measure_r  <= 1'b0;
            lock_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r    <= PULSE;
                    cnt_r      <= 8'd0;
                    smp_r      <= 3'd0;
                    vote_r     <= 3'd0;
                    bit_idx_r  <= 4'd10;
                    code_bin_r <= FIRST_TRIAL;
                    gray_r     <= bin2gray(FIRST_TRIAL);
                    launch_r   <= 1'b1;
                    measure_r  <= 1'b1;
                    lock_r     <= 1'b0;
                    busy_r     <= 1'b1;
                end
                PULSE: begin
                    if (cnt_r == PULSE_LAST) begin
                        state_r   <= SETTLE;
                        cnt_r     <= 8'd0;
                        launch_r  <= 1'b0;
                        measure_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        state_r <= SAMPLE;
                        cnt_r   <= 8'd0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                SAMPLE: begin
                    vote_r <= vote_r + {2'b00, pd_s_r};
                    if (smp_r == SMP_LAST) begin
                        state_r <= DECIDE;
                    end else begin
                        smp_r     <= smp_r + 3'd1;
                        state_r   <= PULSE;
                        launch_r  <= 1'b1;
                        measure_r <= 1'b1;
                    end
                end
                DECIDE: begin
                    code_bin_r <= decide_code_s;
                    gray_r     <= bin2gray(decide_code_s);
                    if (bit_idx_r == 4'd0) begin
                        state_r <= LOCKED;
                        lock_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        bit_idx_r <= bit_idx_r - 4'd1;
                        vote_r    <= 3'd0;
                        smp_r     <= 3'd0;
                        state_r   <= PULSE;
                        launch_r  <= 1'b1;
                        measure_r <= 1'b1;
                    end
                end
                LOCKED: begin
                    launch_r  <= 1'b0;
                    measure_r <= 1'b0;
                    lock_r    <= 1'b1;
                    busy_r    <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= 8'd0;
                    smp_r      <= 3'd0;
                    vote_r     <= 3'd0;
                    bit_idx_r  <= 4'd0;
                    code_bin_r <= 11'd0;
                    gray_r     <= 11'd0;
                    launch_r   <= 1'b0;
                    measure_r  <= 1'b0;
                    lock_r     <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign launch       = launch_r;
    assign measure      = measure_r;
    assign gray         = gray_r;
    assign code_bin     = code_bin_r;
    assign dll_lock_reg = lock_r;
    assign cal_busy     = busy_r;

endmodule
